if_fetch_queue: RTL

- Instruction fetch stage directly upstream of decode; owns the fetch PC and drives it to the branch predictor as PC_F.
- Each cycle it takes the predictor's pred_jump_F/pred_target and the instruction memory read data, pushes {instr, PC, prediction} into a small FIFO, and advances PC_F to the predicted next PC.
- Decode pops entries with a valid/ready handshake and redirects fetch on a misprediction.

---
 rtl/if_fetch_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a small prediction-tagged FIFO toward decode.
// Owns the fetch PC, follows the branch predictor's next-PC on every push,
// stalls when the queue is full or fetch is disabled, and flushes on a
// decode redirect.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] PC_F,
   input  logic        pred_jump_F,
   input  logic [31:0] pred_target,
   input  logic [31:0] imem_rdata,
   output logic        valid_D,
   input  logic        ready_D,
   output logic [31:0] instr_D,
   output logic [31:0] PC_D,
   output logic        pred_jump_D,
   output logic [31:0] pred_target_D,
   input  logic        redirect_D,
   input  logic [31:0] redirect_pc,
   output logic        full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        jump;
      logic [31:0] target;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [31:0]     pc_f_q,   pc_f_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   logic            pop;
   logic            push;
   logic            full_w;
   entry_t          head;

   assign full_w  = (count_q == CW'(DEPTH));
   assign valid_D = (count_q != '0);
   assign full    = full_w;
   assign PC_F    = pc_f_q;

   // A full queue can still take a new entry when decode drains the head in
   // the same cycle; a redirect suppresses the push of the wrong-path fetch.
   assign pop  = valid_D & ready_D;
   assign push = fetch_en & ~redirect_D & (~full_w | pop);

   assign head          = mem_q[rd_ptr_q];
   assign instr_D       = head.instr;
   assign PC_D          = head.pc;
   assign pred_jump_D   = head.jump;
   assign pred_target_D = head.target;

   // Next-state for fetch PC, pointers and occupancy; redirect overrides all.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      pc_f_d   = pc_f_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_D) begin
         pc_f_d   = redirect_pc;
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_f_d   = pred_target;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         pc_f_q   <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_f_q   <= pc_f_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage written on push.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; an entry is only ever read
      // after it was written, because count gates valid_D.
      if (push) begin
         mem_q[wr_ptr_q] <= '{instr:  imem_rdata,
                              pc:     pc_f_q,
                              jump:   pred_jump_F,
                              target: pred_target};
      end
   end

endmodule
